// File: rtl/tt_um_prog_counter_if.sv
// -----------------------------------------------------------------------------
// tt_um_prog_counter_if
//
// Bundles the control, configuration and status signals of the programmable
// counter. Clock and reset are not part of the bundle; they stay plain ports
// on the counter.
//
// Signals (direction as seen from the counter, i.e. the slave modport):
//   en        in   count enable; gates the prescaler
//   up        in   direction, 1 = up, 0 = down
//   sat       in   boundary mode, 1 = saturate, 0 = wrap
//   load      in   synchronous load strobe
//   load_val  in   load value (clamped to mod_val)
//   mod_val   in   upper terminal value, count range 0..mod_val
//   presc     in   count advances once per presc+1 enabled cycles
//   clr_ovf   in   clears the sticky overflow flag
//   cnt       out  registered count
//   tc        out  registered one-cycle terminal-count pulse
//   ovf       out  registered sticky overflow/underflow flag
//
// Modports:
//   master  - drives the controls, observes the status (system / testbench)
//   slave   - the counter itself
// -----------------------------------------------------------------------------
interface tt_um_prog_counter_if #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
);
    logic               en;
    logic               up;
    logic               sat;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic [WIDTH-1:0]   mod_val;
    logic [PRESC_W-1:0] presc;
    logic               clr_ovf;
    logic [WIDTH-1:0]   cnt;
    logic               tc;
    logic               ovf;

    modport master (
        output en, up, sat, load, load_val, mod_val, presc, clr_ovf,
        input  cnt, tc, ovf
    );

    modport slave (
        input  en, up, sat, load, load_val, mod_val, presc, clr_ovf,
        output cnt, tc, ovf
    );
endinterface

// File: rtl/tt_um_prog_counter.sv
// -----------------------------------------------------------------------------
// tt_um_prog_counter
//
// Programmable up/down counter with a prescaler, wrap or saturate boundary
// handling, synchronous load, a terminal-count pulse and a sticky
// overflow/underflow flag. The count range is 0..mod_val.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset (cnt, prescaler, tc, ovf -> 0)
//   bus   slave modport of tt_um_prog_counter_if (controls in, cnt/tc/ovf out)
//
// Per-cycle priority: rst > load > tick > hold. All outputs are registered,
// so a tick or load is visible on cnt one cycle later.
// -----------------------------------------------------------------------------
module tt_um_prog_counter #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic clk,
    input  logic rst,
    tt_um_prog_counter_if.slave bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] p_reg,   p_next;
    logic [WIDTH-1:0]   cnt_reg, cnt_next;
    logic               tc_reg,  tc_next;
    logic               ovf_reg, ovf_next;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               tick;
    logic               ovf_set;
    logic [WIDTH-1:0]   cnt_inc;
    logic [WIDTH-1:0]   cnt_dec;
    logic [WIDTH-1:0]   load_clamped;
    logic               at_top;
    logic               at_zero;

    // The prescaler compares with >= rather than == so that lowering presc
    // below the current prescaler value mid-count produces a tick on the
    // next enabled cycle instead of running the prescaler round its full
    // range.
    assign tick = bus.en && !bus.load && (p_reg >= bus.presc);

    assign cnt_inc = cnt_reg + 1'b1;
    assign cnt_dec = cnt_reg - 1'b1;

    // A count above mod_val (possible after mod_val is lowered) is treated
    // as being at or past the top boundary when counting up.
    assign at_top  = (cnt_reg >= bus.mod_val);
    assign at_zero = (cnt_reg == '0);

    assign load_clamped = (bus.load_val <= bus.mod_val) ? bus.load_val
                                                        : bus.mod_val;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        p_next   = p_reg;
        cnt_next = cnt_reg;
        tc_next  = 1'b0;
        ovf_set  = 1'b0;

        if (bus.load) begin
            cnt_next = load_clamped;
            p_next   = '0;
        end else if (bus.en) begin
            if (tick) begin
                p_next = '0;
                if (bus.up) begin
                    if (at_top) begin
                        ovf_set = 1'b1;
                        if (bus.sat) begin
                            cnt_next = bus.mod_val;
                            tc_next  = 1'b0;
                        end else begin
                            cnt_next = '0;
                            tc_next  = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_inc;
                        // In saturate mode the pulse marks arrival on the
                        // top boundary rather than the wrap.
                        tc_next  = bus.sat && (cnt_inc == bus.mod_val);
                    end
                end else begin
                    if (at_zero) begin
                        ovf_set = 1'b1;
                        if (bus.sat) begin
                            cnt_next = '0;
                            tc_next  = 1'b0;
                        end else begin
                            cnt_next = bus.mod_val;
                            tc_next  = 1'b1;
                        end
                    end else begin
                        // Counting down from above mod_val simply
                        // decrements back into range.
                        cnt_next = cnt_dec;
                        tc_next  = bus.sat && (cnt_reg == {{(WIDTH-1){1'b0}}, 1'b1});
                    end
                end
            end else begin
                p_next = p_reg + 1'b1;
            end
        end

        // A new overflow in the same cycle as a clear request wins, so an
        // event is never lost.
        if (ovf_set) begin
            ovf_next = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_next = 1'b0;
        end else begin
            ovf_next = ovf_reg;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg   <= '0;
            cnt_reg <= '0;
            tc_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            p_reg   <= p_next;
            cnt_reg <= cnt_next;
            tc_reg  <= tc_next;
            ovf_reg <= ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cnt = cnt_reg;
    assign bus.tc  = tc_reg;
    assign bus.ovf = ovf_reg;

endmodule

// File: tb/tb_tt_um_prog_counter.sv
// -----------------------------------------------------------------------------
// tb_tt_um_prog_counter
//
// Directed, self-checking bench for tt_um_prog_counter (WIDTH=8, PRESC_W=4).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, i.e. after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_tt_um_prog_counter;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 4;

    logic clk;
    logic rst;

    int checks;
    int errors;

    tt_um_prog_counter_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

    tt_um_prog_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int t, input int o);
        chk({tag, ".cnt"}, 32'(bus.cnt), c);
        chk({tag, ".tc"},  32'(bus.tc),  t);
        chk({tag, ".ovf"}, 32'(bus.ovf), o);
        $display("%-14s cnt=%0d tc=%0d ovf=%0d", tag, bus.cnt, bus.tc, bus.ovf);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        bus.sat      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.mod_val  = 8'd255;
        bus.presc    = '0;
        bus.clr_ovf  = 1'b0;

        // ---------------- Reset ----------------
        step();
        step();
        chk_all("reset", 0, 0, 0);

        // ---------------- Free run 0..255, wrap ----------------
        rst    = 1'b0;
        bus.en = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            step();
            chk("free.cnt", 32'(bus.cnt), i);
            chk("free.tc",  32'(bus.tc),  0);
        end
        $display("free run reached cnt=%0d", bus.cnt);
        step();
        chk_all("free.wrap", 0, 1, 1);
        step();
        chk_all("free.after", 1, 0, 1);

        // ---------------- Clear ovf while idle ----------------
        bus.en      = 1'b0;
        bus.clr_ovf = 1'b1;
        step();
        chk_all("clr_ovf", 1, 0, 0);
        bus.clr_ovf = 1'b0;

        // ---------------- Up, saturate, presc=2, mod=9 ----------------
        bus.en       = 1'b1;
        bus.sat      = 1'b1;
        bus.presc    = 4'd2;
        bus.mod_val  = 8'd9;
        bus.load_val = 8'd0;
        bus.load     = 1'b1;
        step();
        chk_all("sat.load", 0, 0, 0);
        bus.load = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("sat.hold1", 32'(bus.cnt), k - 1);
            step();
            chk("sat.hold2", 32'(bus.cnt), k - 1);
            step();
            chk("sat.cnt", 32'(bus.cnt), k);
            chk("sat.tc",  32'(bus.tc), (k == 9) ? 1 : 0);
            $display("sat tick cnt=%0d tc=%0d", bus.cnt, bus.tc);
        end
        step();
        step();
        chk_all("sat.pre", 9, 0, 0);
        step();
        chk_all("sat.ovf", 9, 0, 1);

        // ---------------- Down, wrap, mod=5, load 2 ----------------
        bus.en      = 1'b0;
        bus.clr_ovf = 1'b1;
        step();
        chk_all("dn.clr", 9, 0, 0);
        bus.clr_ovf  = 1'b0;
        bus.en       = 1'b1;
        bus.up       = 1'b0;
        bus.sat      = 1'b0;
        bus.presc    = 4'd0;
        bus.mod_val  = 8'd5;
        bus.load_val = 8'd2;
        bus.load     = 1'b1;
        step();
        chk_all("dn.load", 2, 0, 0);
        bus.load = 1'b0;
        step();
        chk_all("dn.1", 1, 0, 0);
        step();
        chk_all("dn.0", 0, 0, 0);
        step();
        chk_all("dn.wrap", 5, 1, 1);
        step();
        chk_all("dn.4", 4, 0, 1);

        // ---------------- Load clamp coinciding with a due tick ----------------
        bus.up       = 1'b1;
        bus.presc    = 4'd1;
        bus.mod_val  = 8'd50;
        bus.load_val = 8'd10;
        bus.load     = 1'b1;
        step();
        chk_all("ld.a", 10, 0, 1);
        bus.load = 1'b0;
        step();                         // prescaler now at 1: tick due next
        chk_all("ld.p1", 10, 0, 1);
        bus.load_val = 8'd200;
        bus.load     = 1'b1;
        step();
        chk_all("ld.clamp", 50, 0, 1);
        bus.load = 1'b0;
        step();                         // prescaler restarted at 0: no tick
        chk_all("ld.p0", 50, 0, 1);
        step();
        chk_all("ld.wrap", 0, 1, 1);

        // ---------------- en gating with presc=1 ----------------
        bus.load_val = 8'd0;
        bus.load     = 1'b1;
        step();
        chk_all("en.load", 0, 0, 1);
        bus.load = 1'b0;
        step();
        chk_all("en.e1", 0, 0, 1);
        bus.en = 1'b0;
        step();
        chk_all("en.d1", 0, 0, 1);
        step();
        chk_all("en.d2", 0, 0, 1);
        bus.en = 1'b1;
        step();
        chk_all("en.tick", 1, 0, 1);
        bus.en = 1'b0;
        step();
        chk_all("en.d3", 1, 0, 1);
        bus.en = 1'b1;
        step();
        chk_all("en.e2", 1, 0, 1);
        step();
        chk_all("en.tick2", 2, 0, 1);

        // ---------------- Down, saturate, arrival pulse on 0 ----------------
        bus.en      = 1'b0;
        bus.clr_ovf = 1'b1;
        step();
        chk_all("ds.clr", 2, 0, 0);
        bus.clr_ovf  = 1'b0;
        bus.en       = 1'b1;
        bus.up       = 1'b0;
        bus.sat      = 1'b1;
        bus.presc    = 4'd0;
        bus.mod_val  = 8'd9;
        bus.load_val = 8'd2;
        bus.load     = 1'b1;
        step();
        chk_all("ds.load", 2, 0, 0);
        bus.load = 1'b0;
        step();
        chk_all("ds.1", 1, 0, 0);
        step();
        chk_all("ds.0", 0, 1, 0);
        step();
        chk_all("ds.under", 0, 0, 1);

        // ---------------- Count above mod_val decrements ----------------
        bus.sat      = 1'b0;
        bus.load_val = 8'd9;
        bus.load     = 1'b1;
        step();
        chk_all("hi.load", 9, 0, 1);
        bus.load    = 1'b0;
        bus.mod_val = 8'd5;
        step();
        chk_all("hi.dec", 8, 0, 1);

        // ---------------- mod_val = 0, wrap ----------------
        bus.up       = 1'b1;
        bus.mod_val  = 8'd0;
        bus.load_val = 8'd7;
        bus.load     = 1'b1;
        bus.clr_ovf  = 1'b1;
        step();
        chk("m0.load", 32'(bus.cnt), 0);
        bus.load    = 1'b0;
        bus.clr_ovf = 1'b0;
        step();
        chk_all("m0.t1", 0, 1, 1);
        step();
        chk_all("m0.t2", 0, 1, 1);

        // ---------------- clr_ovf coinciding with wrap ----------------
        bus.mod_val  = 8'd3;
        bus.load_val = 8'd3;
        bus.load     = 1'b1;
        step();
        chk_all("cw.load", 3, 0, 1);
        bus.load    = 1'b0;
        bus.clr_ovf = 1'b1;
        step();
        chk_all("cw.wrap", 0, 1, 1);
        step();
        chk_all("cw.clr", 1, 0, 0);
        bus.clr_ovf = 1'b0;
        step();
        chk_all("cw.2", 2, 0, 0);
        step();
        chk_all("cw.3", 3, 0, 0);
        step();
        chk_all("cw.w2", 0, 1, 1);

        // ---------------- Load mid-count keeps ovf ----------------
        bus.load_val = 8'd2;
        bus.load     = 1'b1;
        step();
        chk_all("lk.load", 2, 0, 1);
        bus.load = 1'b0;

        // ---------------- Reset mid-count overrides load ----------------
        rst      = 1'b1;
        bus.load = 1'b1;
        step();
        chk_all("rs.rst", 0, 0, 0);
        rst      = 1'b0;
        bus.load = 1'b0;
        step();
        chk_all("rs.resume", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
